// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: single-port synchronous RAM behind a valid/ready request
// channel, with a registered one-cycle response and optional clear-on-reset.
module sync_ram_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam state_t RST_STATE = INIT_ON_RESET ? INIT : IDLE;

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_we;
  logic                  accept;
  logic                  in_range;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  err_d;

  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign wr_en    = accept && req_write && in_range;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs, decoded from the state register only.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    init_busy = 1'b0;
    init_we   = 1'b0;
    unique case (state_q)
      INIT: begin
        init_busy = 1'b1;
        init_we   = 1'b1;
        // Exit on the last-word compare, not on counter wrap.
        if (cnt_q == LAST) state_d = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Clear-sequence address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (init_we) cnt_q <= cnt_q + 1'b1;
  end

  // Array write port: clear sequence or accepted in-range write.
  always_ff @(posedge clk) begin
    if (init_we)    mem[cnt_q]    <= '0;
    else if (wr_en) mem[req_addr] <= req_wdata;
  end

  // Response payload: read data only for in-range reads.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (accept) begin
      if (!in_range)      err_d   = 1'b1;
      else if (!req_write) rdata_d = mem[req_addr];
    end
  end

  // Registered response channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// tb_sync_ram_ctrl: directed bench for sync_ram_ctrl covering default,
// reduced-depth and no-clear configurations.
module tb_sync_ram_ctrl;

  logic       clk;
  logic       rst0, rst1, rst2;
  logic       req_valid;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;

  logic       rdy0, rdy1, rdy2;
  logic       vld0, vld1, vld2;
  logic [7:0] rd0, rd1, rd2;
  logic       err0, err1, err2;
  logic       bsy0, bsy1, bsy2;

  int nvec = 0;
  int nerr = 0;

  sync_ram_ctrl u0 (
    .clk(clk), .rst_n(rst0),
    .req_valid(req_valid), .req_ready(rdy0),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld0),
    .rsp_rdata(rd0), .rsp_err(err0),
    .init_busy(bsy0)
  );

  sync_ram_ctrl #(.DEPTH(12)) u1 (
    .clk(clk), .rst_n(rst1),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld1),
    .rsp_rdata(rd1), .rsp_err(err1),
    .init_busy(bsy1)
  );

  sync_ram_ctrl #(.INIT_ON_RESET(1'b0)) u2 (
    .clk(clk), .rst_n(rst2),
    .req_valid(req_valid), .req_ready(rdy2),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld2),
    .rsp_rdata(rd2), .rsp_err(err2),
    .init_busy(bsy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [3:0] a,
                     input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    idle();
    tick(); tick();
    chk("rst_vld0", vld0, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_bsy0", bsy0, 1);

    // Default instance: 16-edge clear with a request pending throughout.
    rst0 = 1'b1;
    req(1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      chk("init_bsy", bsy0, 1);
      chk("init_rdy", rdy0, 0);
      tick();
      chk("init_novld", vld0, 0);
    end
    chk("post_bsy", bsy0, 0);
    chk("post_rdy", rdy0, 1);

    for (int k = 0; k < 16; k++) begin
      req(1'b0, 4'(k), 8'h00);
      tick();
      chk("clr_vld", vld0, 1);
      chk("clr_rd", rd0, 0);
      chk("clr_err", err0, 0);
    end

    // Write then read-after-write.
    req(1'b1, 4'd3, 8'hA5);
    tick();
    chk("wr_vld", vld0, 1);
    chk("wr_rd", rd0, 8'h00);
    req(1'b0, 4'd3, 8'h00);
    tick();
    chk("raw_vld", vld0, 1);
    chk("raw_rd", rd0, 8'hA5);

    // Back-to-back stream of 16 writes then 16 reads.
    for (int k = 0; k < 16; k++) begin
      req(1'b1, 4'(k), 8'(k + 16));
      tick();
      chk("strw_vld", vld0, 1);
      chk("strw_rd", rd0, 0);
    end
    for (int k = 0; k < 16; k++) begin
      req(1'b0, 4'(k), 8'h00);
      tick();
      chk("strr_vld", vld0, 1);
      chk("strr_rd", rd0, 8'(k + 16));
    end
    idle();
    tick();
    chk("gap_vld", vld0, 0);
    chk("gap_rd", rd0, 0);
    chk("gap_err", err0, 0);

    // Reset in the middle of a transaction drops the response.
    req(1'b0, 4'd3, 8'h00);
    tick();
    chk("pre_rd", rd0, 8'h13);
    rst0 = 1'b0;
    #1;
    chk("mid_vld", vld0, 0);
    chk("mid_rd", rd0, 0);
    chk("mid_bsy", bsy0, 1);
    chk("mid_rdy", rdy0, 0);
    tick();
    rst0 = 1'b1;

    // Reset again at INIT cycle 5 with a request pending.
    for (int i = 0; i < 5; i++) tick();
    chk("i5_bsy", bsy0, 1);
    rst0 = 1'b0;
    #1;
    chk("i5r_vld", vld0, 0);
    chk("i5r_rdy", rdy0, 0);
    tick();
    rst0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("re_rdy", rdy0, 0);
      tick();
      chk("re_novld", vld0, 0);
    end
    chk("re_rdy_up", rdy0, 1);
    tick();
    chk("re_acc_vld", vld0, 1);
    chk("re_acc_rd", rd0, 8'h00);
    idle();
    rst0 = 1'b0;

    // DEPTH=12 instance: 12-edge clear and out-of-range errors.
    rst1 = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("d12_bsy", bsy1, 1);
    tick();
    chk("d12_rdy", rdy1, 1);
    req(1'b1, 4'd11, 8'h5A);
    tick();
    chk("d12_w11", err1, 0);
    req(1'b1, 4'd13, 8'hFF);
    tick();
    chk("oob_w_vld", vld1, 1);
    chk("oob_w_err", err1, 1);
    chk("oob_w_rd", rd1, 0);
    req(1'b0, 4'd13, 8'h00);
    tick();
    chk("oob_r_err", err1, 1);
    chk("oob_r_rd", rd1, 0);
    req(1'b0, 4'd12, 8'h00);
    tick();
    chk("oob12_err", err1, 1);
    req(1'b0, 4'd11, 8'h00);
    tick();
    chk("r11_vld", vld1, 1);
    chk("r11_err", err1, 0);
    chk("r11_rd", rd1, 8'h5A);
    idle();
    tick();
    chk("d12_gap", vld1, 0);
    rst1 = 1'b0;

    // INIT_ON_RESET=0 instance: ready straight out of reset.
    rst2 = 1'b1;
    #1;
    chk("ni_rdy", rdy2, 1);
    chk("ni_bsy", bsy2, 0);
    req(1'b1, 4'd0, 8'h3C);
    tick();
    chk("ni_wvld", vld2, 1);
    req(1'b0, 4'd0, 8'h00);
    tick();
    chk("ni_rd", rd2, 8'h3C);
    chk("ni_err", err2, 0);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
